// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares the single-port unified memory (async read, sync write) between the
//   instruction-fetch port (IF) and the data port (D). One transaction at a time:
//   IDLE -> ACCESS (LATENCY cycles) -> RESP (one-cycle ready pulse) -> IDLE.
//
// Ports
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   if_req_i, if_addr_i             IF request and byte address
//   if_ready_o, if_rdata_o          IF done pulse, read data register
//   d_req_i, d_we_i                 D request, 1 = write
//   d_addr_i, d_wdata_i             D byte address and write data
//   d_ready_o, d_rdata_o            D done pulse, read data register (0 after write)
//   mem_addr_o, mem_din_o           memory address / write data (0 outside ACCESS)
//   mem_read_o, mem_write_o         memory strobes
//   mem_dout_i                      memory read data
//   busy_o                          high whenever a transaction is in flight
module mem_access_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter bit          FAIR    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_dout_i,
  output logic        busy_o
);

  localparam int unsigned    CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             owner_q, owner_d;  // 0 = IF, 1 = D
  logic             last_q, last_d;    // owner of the most recent completed transaction
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             grant_d;

  // D wins when alone, under fixed priority, or when IF was served last.
  assign grant_d = d_req_i & (~if_req_i | ~FAIR | ~last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (if_req_i | d_req_i) begin
          owner_d = grant_d;
          addr_d  = grant_d ? d_addr_i : if_addr_i;
          wdata_d = grant_d ? d_wdata_i : '0;
          we_d    = grant_d & d_we_i;
          cnt_d   = CntInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          rdata_d = we_q ? '0 : mem_dout_i;
          state_d = StResp;
        end
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  logic in_access, in_resp;
  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);

  // Outputs decode straight from state so an async reset clears them at once.
  assign mem_addr_o  = in_access ? addr_q : '0;
  assign mem_din_o   = in_access ? wdata_q : '0;
  assign mem_read_o  = in_access & ~we_q;
  assign mem_write_o = in_access & we_q & (cnt_q == '0);
  assign if_ready_o  = in_resp & ~owner_q;
  assign d_ready_o   = in_resp & owner_q;
  assign if_rdata_o  = rdata_q;
  assign d_rdata_o   = rdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  localparam int L0 = 2;  // dut0: LATENCY=2, FAIR=1
  localparam int L1 = 1;  // dut1: LATENCY=1, FAIR=0

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  logic        if_req0 = 0, d_req0 = 0, d_we0 = 0;
  logic [31:0] if_addr0 = 0, d_addr0 = 0, d_wdata0 = 0;
  logic        if_ready0, d_ready0, m_rd0, m_wr0, busy0;
  logic [31:0] if_rdata0, d_rdata0, m_addr0, m_din0, m_dout0;

  logic        if_req1 = 0, d_req1 = 0, d_we1 = 0;
  logic [31:0] if_addr1 = 0, d_addr1 = 0, d_wdata1 = 0;
  logic        if_ready1, d_ready1, m_rd1, m_wr1, busy1;
  logic [31:0] if_rdata1, d_rdata1, m_addr1, m_din1, m_dout1;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] ref_mem [256];

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h00500093;
      1: return 32'h11111111;
      2: return 32'h22222222;
      default: return 32'hA5000000 | 32'(i);
    endcase
  endfunction

  // Behavioural memories: async read gated by mem_read, write on clock edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= init_word(i);
        mem1[i] <= init_word(i);
      end
    end else begin
      if (m_wr0) mem0[m_addr0[9:2]] <= m_din0;
      if (m_wr1) mem1[m_addr1[9:2]] <= m_din1;
    end
  end
  assign m_dout0 = m_rd0 ? mem0[m_addr0[9:2]] : 32'h0;
  assign m_dout1 = m_rd1 ? mem1[m_addr1[9:2]] : 32'h0;

  mem_access_arbiter #(.LATENCY(L0), .FAIR(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req0), .if_addr_i(if_addr0), .if_ready_o(if_ready0), .if_rdata_o(if_rdata0),
    .d_req_i(d_req0), .d_we_i(d_we0), .d_addr_i(d_addr0), .d_wdata_i(d_wdata0),
    .d_ready_o(d_ready0), .d_rdata_o(d_rdata0),
    .mem_addr_o(m_addr0), .mem_din_o(m_din0), .mem_read_o(m_rd0), .mem_write_o(m_wr0),
    .mem_dout_i(m_dout0), .busy_o(busy0)
  );

  mem_access_arbiter #(.LATENCY(L1), .FAIR(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req1), .if_addr_i(if_addr1), .if_ready_o(if_ready1), .if_rdata_o(if_rdata1),
    .d_req_i(d_req1), .d_we_i(d_we1), .d_addr_i(d_addr1), .d_wdata_i(d_wdata1),
    .d_ready_o(d_ready1), .d_rdata_o(d_rdata1),
    .mem_addr_o(m_addr1), .mem_din_o(m_din1), .mem_read_o(m_rd1), .mem_write_o(m_wr1),
    .mem_dout_i(m_dout1), .busy_o(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle0();
    for (int i = 0; i < 20 && busy0; i++) @(negedge clk);
    chk("idle0", {31'd0, busy0}, 32'd0);
  endtask

  typedef struct packed {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        we;
    logic [31:0] da;
    logic [31:0] wd;
    logic        exp_d;   // 1 = D expected to win
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  // Transaction-level reference model for dut0.
  bit          m_act, m_own, m_last, m_we;
  int          m_ph;
  logic [31:0] m_addr, m_wdata, m_rdata;

  initial begin
    int n, wr_cnt, rd_cnt, k, dcnt, icnt, prev;
    bit got;
    logic [4:0]  e_ctrl;
    logic        ifr, dr, e_acc, e_resp;

    // reset-state check
    @(negedge clk);
    @(negedge clk);
    chk("rst_out0", {busy0, if_ready0, d_ready0, m_rd0, m_wr0} | m_addr0 | m_din0 | d_rdata0,
        32'd0);
    chk("rst_out1", {busy1, if_ready1, d_ready1, m_rd1, m_wr1} | m_addr1 | m_din1 | d_rdata1,
        32'd0);
    mem_init = 1'b0;
    rst = 1'b0;

    // ifr, ia, dr, we, da, wd, exp_d, exp_rd
    vecs[0] = '{1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h00500093};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 32'h4,   1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h11111111};
    vecs[4] = '{1'b1, 32'h0,   1'b1, 1'b1, 32'h40,  32'hCAFEF00D, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h8,   32'h0,        1'b1, 32'h22222222};
    vecs[7] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 32'hDEADBEEF};

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      if_req0 = vecs[v].ifr; if_addr0 = vecs[v].ia;
      d_req0 = vecs[v].dr; d_we0 = vecs[v].we; d_addr0 = vecs[v].da; d_wdata0 = vecs[v].wd;
      n = 0; got = 0; wr_cnt = 0; rd_cnt = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        wr_cnt += int'(m_wr0);
        rd_cnt += int'(m_rd0);
        if (if_ready0 || d_ready0) got = 1;
      end
      chk($sformatf("v%0d_latency", v), n, L0 + 1);
      chk($sformatf("v%0d_ready", v), {if_ready0, d_ready0}, vecs[v].exp_d ? 2'b01 : 2'b10);
      chk($sformatf("v%0d_d_rdata", v), d_rdata0, vecs[v].exp_rd);
      chk($sformatf("v%0d_if_rdata", v), if_rdata0, vecs[v].exp_rd);
      chk($sformatf("v%0d_wr_cycles", v), wr_cnt, (vecs[v].exp_d && vecs[v].we) ? 1 : 0);
      chk($sformatf("v%0d_rd_cycles", v), rd_cnt, (vecs[v].exp_d && vecs[v].we) ? 0 : L0);
      if_req0 = 0; d_req0 = 0; d_we0 = 0;
      @(negedge clk);
      chk($sformatf("v%0d_after", v), {busy0, if_ready0, d_ready0}, 3'b000);
    end

    // Round-robin with both requests held: D, IF, D, IF every LATENCY+2 cycles.
    do_reset();
    @(negedge clk);
    if_req0 = 1; if_addr0 = 32'h0; d_req0 = 1; d_we0 = 0; d_addr0 = 32'h100;
    k = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (if_ready0 || d_ready0) begin
        chk($sformatf("rr%0d_who", k), {if_ready0, d_ready0}, (k % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("rr%0d_pos", k), c, 3 + 4 * k);
        chk($sformatf("rr%0d_data", k), d_rdata0, (k % 2 == 0) ? 32'hDEADBEEF : 32'h00500093);
        k++;
      end
    end
    chk("rr_count", k, 4);
    if_req0 = 0; d_req0 = 0;
    wait_idle0();

    // Fixed priority on dut1: IF starved.
    @(negedge clk);
    if_req1 = 1; if_addr1 = 32'h0; d_req1 = 1; d_we1 = 0; d_addr1 = 32'h4;
    dcnt = 0; icnt = 0; prev = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (if_ready1) icnt++;
      if (d_ready1) begin
        chk($sformatf("fp%0d_pos", dcnt), c, (prev < 0) ? 2 : prev + 3);
        chk($sformatf("fp%0d_data", dcnt), d_rdata1, 32'h11111111);
        prev = c;
        dcnt++;
      end
    end
    chk("fp_d_count", dcnt, 4);
    chk("fp_if_count", icnt, 0);
    if_req1 = 0; d_req1 = 0;
    @(negedge clk);
    @(negedge clk);

    // LATENCY=1 back-to-back IF reads.
    if_req1 = 1; if_addr1 = 32'h0;
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (if_ready1) begin
        chk($sformatf("b2b%0d_pos", k), c, 2 + 3 * k);
        chk($sformatf("b2b%0d_data", k), if_rdata1, init_word(k));
        k++;
        if_addr1 = 32'(k) << 2;
        if (k == 3) if_req1 = 0;
      end
    end
    chk("b2b_count", k, 3);

    // Reset during the first ACCESS cycle of a write.
    @(negedge clk);
    d_req0 = 1; d_we0 = 1; d_addr0 = 32'h40; d_wdata0 = 32'h12345678;
    @(negedge clk);
    chk("abort_busy_before", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {busy0, if_ready0, d_ready0, m_rd0, m_wr0} | m_addr0 | m_din0 | d_rdata0,
        32'd0);
    d_req0 = 0; d_we0 = 0;
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_ready0) dcnt++;
    end
    chk("abort_no_ready", dcnt, 0);
    chk("abort_mem", mem0[16], 32'hCAFEF00D);

    // Request dropped one cycle after accept.
    @(negedge clk);
    d_req0 = 1; d_we0 = 0; d_addr0 = 32'h0;
    @(negedge clk);
    d_req0 = 0; d_addr0 = 32'h4;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_ready0) begin
        dcnt++;
        chk("drop_data", d_rdata0, 32'h00500093);
      end
    end
    chk("drop_ready_count", dcnt, 1);
    chk("drop_busy", {31'd0, busy0}, 32'd0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    ref_mem = mem0;
    m_act = 0; m_own = 0; m_last = 0; m_we = 0; m_ph = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e_acc  = m_act && (m_ph < L0);
      e_resp = m_act && (m_ph == L0);
      e_ctrl = {m_act, e_resp && !m_own, e_resp && m_own, e_acc && !m_we,
                e_acc && m_we && (m_ph == L0 - 1)};
      chk($sformatf("rnd%0d_ctrl", c), {busy0, if_ready0, d_ready0, m_rd0, m_wr0}, e_ctrl);
      chk($sformatf("rnd%0d_addr", c), m_addr0, e_acc ? m_addr : 32'h0);
      chk($sformatf("rnd%0d_rdata", c), d_rdata0, m_rdata);
      if (e_acc && m_we) chk($sformatf("rnd%0d_din", c), m_din0, m_wdata);
      if_req0  = ($urandom_range(0, 2) != 0);
      d_req0   = ($urandom_range(0, 2) != 0);
      d_we0    = $urandom_range(0, 1) == 1;
      if_addr0 = 32'($urandom_range(0, 31)) << 2;
      d_addr0  = 32'($urandom_range(0, 31)) << 2;
      d_wdata0 = $urandom;
      @(posedge clk);
      ifr = if_req0;
      dr  = d_req0;
      if (!m_act) begin
        if (ifr || dr) begin
          if (ifr && dr) m_own = FAIR_WIN(m_last);
          else m_own = dr;
          m_addr  = m_own ? d_addr0 : if_addr0;
          m_we    = m_own && d_we0;
          m_wdata = m_own ? d_wdata0 : 32'h0;
          m_act   = 1;
          m_ph    = 0;
        end
      end else if (m_ph < L0 - 1) begin
        m_ph++;
      end else if (m_ph == L0 - 1) begin
        if (m_we) begin
          ref_mem[m_addr[9:2]] = m_wdata;
          m_rdata = 32'h0;
        end else begin
          m_rdata = ref_mem[m_addr[9:2]];
        end
        m_ph = L0;
      end else begin
        m_last = m_own;
        m_act  = 0;
      end
    end
    if_req0 = 0; d_req0 = 0;
    wait_idle0();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Under round-robin the requester that was not served last wins (1 = D).
  function automatic bit FAIR_WIN(input bit last_was_d);
    return !last_was_d;
  endfunction

endmodule
